// File: rtl/shift_reg_driver.sv
// Command sequencer for a WIDTH-bit shift register. It accepts a command (initial word,
// direction, mode, step count, per-step serial bits), applies the operation count times by
// feeding each sampled dataout back as the next datain, and returns the final word on a
// valid/ready result port.
// Optional build macro SHIFT_DRV_CHECK_EN adds a per-step reference check with a sticky
// err_mismatch output.
module shift_reg_driver #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned MAX_STEPS  = 8,
  parameter int unsigned SR_LATENCY = 1,
  localparam int unsigned CNT_W     = $clog2(MAX_STEPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_data,
  input  logic                 cmd_dir,
  input  logic                 cmd_mode,
  input  logic [CNT_W-1:0]     cmd_count,
  input  logic [MAX_STEPS-1:0] cmd_serial,
  output logic [WIDTH-1:0]     sr_datain,
  output logic                 sr_serial_in,
  output logic                 sr_direction,
  output logic                 sr_mode,
  input  logic [WIDTH-1:0]     sr_dataout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 busy
`ifdef SHIFT_DRV_CHECK_EN
  ,
  output logic                 err_mismatch
`endif
);

  localparam int unsigned LAT_W = (SR_LATENCY < 1) ? 1 : $clog2(SR_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StStep, StResult} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cur_q, cur_d;
  logic                 dir_q, dir_d;
  logic                 mode_q, mode_d;
  // Serial bits shift down one place per step, so bit 0 is always the current step's bit.
  logic [MAX_STEPS-1:0] serial_q, serial_d;
  logic [CNT_W-1:0]     steps_q, steps_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 sample;

  // Sample cycle: last cycle of a step, when dataout reflects the inputs driven this step.
  assign sample = (state_q == StStep) && (lat_q == '0);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      dir_q    <= 1'b0;
      mode_q   <= 1'b0;
      serial_q <= '0;
      steps_q  <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      serial_q <= serial_d;
      steps_q  <= steps_d;
      lat_q    <= lat_d;
    end
  end

  // Next-state logic and outputs.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    serial_d     = serial_q;
    steps_d      = steps_q;
    lat_d        = lat_q;
    sr_serial_in = 1'b0;
    sr_direction = 1'b0;
    sr_mode      = 1'b0;
    cmd_ready    = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          cur_d    = cmd_data;
          dir_d    = cmd_dir;
          mode_d   = cmd_mode;
          serial_d = cmd_serial;
          steps_d  = (cmd_count > CNT_W'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : cmd_count;
          lat_d    = LAT_W'(SR_LATENCY);
          state_d  = (steps_d == '0) ? StResult : StStep;
        end
      end
      StStep: begin
        sr_serial_in = serial_q[0];
        sr_direction = dir_q;
        sr_mode      = mode_q;
        if (sample) begin
          cur_d    = sr_dataout;
          serial_d = serial_q >> 1;
          steps_d  = steps_q - CNT_W'(1);
          lat_d    = LAT_W'(SR_LATENCY);
          if (steps_q == CNT_W'(1)) begin
            state_d = StResult;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      StResult: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sr_datain = cur_q;
  assign res_data  = cur_q;

`ifdef SHIFT_DRV_CHECK_EN
  logic [WIDTH-1:0] exp_word;
  logic             err_q;

  // Expected shift register result for the step currently being driven.
  always_comb begin
    unique case ({mode_q, dir_q})
      2'b11:   exp_word = {cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
      2'b10:   exp_word = {cur_q[0], cur_q[WIDTH-1:1]};
      2'b01:   exp_word = {cur_q[WIDTH-2:0], serial_q[0]};
      default: exp_word = {serial_q[0], cur_q[WIDTH-1:1]};
    endcase
  end

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (sample && (sr_dataout != exp_word)) begin
      err_q <= 1'b1;
    end
  end

  assign err_mismatch = err_q;
`endif

endmodule
